// File: rtl/debug_display_scheduler_if.sv
// Signal bundle between a debug-word source and the 4-digit display scheduler.
// The source drives the words and the selection controls; the scheduler drives
// the multiplexed 7-segment outputs and reports which word is on screen.
interface debug_display_scheduler_if;
  logic [15:0] in_sign1;
  logic [15:0] in_sign2;
  logic [15:0] in_sign3;
  logic [15:0] in_sign4;
  logic        mode;
  logic [1:0]  sel;
  logic        hold;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  cur_sel;

  modport master (
    output in_sign1, in_sign2, in_sign3, in_sign4, mode, sel, hold,
    input  an, seg, dp, cur_sel
  );

  modport slave (
    input  in_sign1, in_sign2, in_sign3, in_sign4, mode, sel, hold,
    output an, seg, dp, cur_sel
  );
endinterface

// File: rtl/debug_display_scheduler.sv
// Time-multiplexed 4-digit hex display for four 16-bit debug words.
// A prescaler paces the digit scan; at the end of each 4-digit frame the
// displayed word is either taken from sel (manual) or rotated after
// ROTATE_FRAMES frames (auto), and its value is snapshotted so the digits of
// one frame always come from a single consistent sample. hold freezes the
// word choice and snapshot while the scan keeps refreshing the display.
module debug_display_scheduler #(
  parameter int SCAN_DIV      = 100000,
  parameter int ROTATE_FRAMES = 256
) (
  input logic                     CLK,
  input logic                     Reset,
  debug_display_scheduler_if.slave bus
);

  localparam int PRE_W   = $clog2(SCAN_DIV);
  localparam int FRAME_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ROTATE_FRAMES - 1);

  // Registered state
  logic [PRE_W-1:0]   prescaler;
  logic [1:0]         digit;
  logic [FRAME_W-1:0] frame_cnt;
  logic [1:0]         word_idx;
  logic [15:0]        snapshot;

  // Frame-boundary decisions
  logic               tick;
  logic               frame_end;
  logic [1:0]         next_idx;
  logic [FRAME_W-1:0] next_frame;
  logic [15:0]        next_word;
  logic [3:0]         nibble;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  // Scan pacing: one tick per digit slot, a frame ends after the last digit.
  always_comb begin
    tick      = (prescaler == PRE_LAST);
    frame_end = tick && (digit == 2'd3);
  end

  // Word choice for the coming frame and the value to snapshot with it.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    next_idx   = word_idx;
    next_frame = frame_cnt;
    if (!bus.mode) begin
      next_idx = bus.sel;
    end else if (frame_cnt == FRAME_LAST) begin
      next_frame = '0;
      next_idx   = word_idx + 2'd1;
    end else begin
      next_frame = frame_cnt + FRAME_W'(1);
    end

    case (next_idx)
      2'd0:    next_word = bus.in_sign1;
      2'd1:    next_word = bus.in_sign2;
      2'd2:    next_word = bus.in_sign3;
      default: next_word = bus.in_sign4;
    endcase
  end

  // State update: the scan always runs; word state only moves at an unheld
  // frame boundary. Reset wins over everything and restarts at digit 0.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      prescaler <= '0;
      digit     <= 2'd0;
      frame_cnt <= '0;
      word_idx  <= 2'd0;
      snapshot  <= 16'h0000;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      if (tick) begin
        digit <= digit + 2'd1;
      end
      if (frame_end && !bus.hold) begin
        word_idx  <= next_idx;
        frame_cnt <= next_frame;
        snapshot  <= next_word;
      end
    end
  end

  // Display decode from registered state only; the digit under the scan is
  // driven in the same cycle it becomes current.
  always_comb begin
    nibble = snapshot[{digit, 2'b00} +: 4];
  end

  assign bus.an      = ~(4'b0001 << digit);
  assign bus.seg     = hex_to_seg(nibble);
  assign bus.dp      = (digit == word_idx) ? 1'b0 : 1'b1;
  assign bus.cur_sel = word_idx;

endmodule

// File: tb/tb_debug_display_scheduler.sv
// Self-checking bench for debug_display_scheduler (SCAN_DIV=4, ROTATE_FRAMES=2).
// Every cycle the outputs are compared with a cycle-count based reference
// model; table vectors and directed sequences add fixed expected values.
module tb_debug_display_scheduler;

  localparam int SD = 4;
  localparam int RF = 2;

  logic CLK;
  logic Reset;

  debug_display_scheduler_if bus ();

  debug_display_scheduler #(
    .SCAN_DIV      (SD),
    .ROTATE_FRAMES (RF)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position in the scan is just the number of clean
  // cycles since reset; words change only at multiples of one frame.
  int          m_cyc;
  logic [1:0]  m_idx;
  int          m_frames;
  logic [15:0] m_snap;

  typedef struct {
    logic [15:0]      word;
    logic [1:0]       sel;
    logic [3:0][6:0]  seg_exp;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'b1000000; 4'h1: c = 7'b1111001; 4'h2: c = 7'b0100100;
      4'h3: c = 7'b0110000; 4'h4: c = 7'b0011001; 4'h5: c = 7'b0010010;
      4'h6: c = 7'b0000010; 4'h7: c = 7'b1111000; 4'h8: c = 7'b0000000;
      4'h9: c = 7'b0010000; 4'hA: c = 7'b0001000; 4'hB: c = 7'b0000011;
      4'hC: c = 7'b1000110; 4'hD: c = 7'b0100001; 4'hE: c = 7'b0000110;
      default: c = 7'b0001110;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    int         dig;
    logic [3:0] e_an;
    logic [3:0] nib;
    dig  = (m_cyc / SD) % 4;
    e_an = 4'b1111;
    e_an[dig] = 1'b0;
    nib  = 4'((m_snap >> (4 * dig)) & 16'h000F);
    check("model_an",      32'(bus.an),      32'(e_an));
    check("model_seg",     32'(bus.seg),     32'(ref_seg(nib)));
    check("model_dp",      32'(bus.dp),      32'((dig == int'(m_idx)) ? 1'b0 : 1'b1));
    check("model_cur_sel", 32'(bus.cur_sel), 32'(m_idx));
  endtask

  // One clock: sample the inputs the edge will see, advance the model, compare.
  task automatic step();
    logic        rst_s, hold_s, mode_s;
    logic [1:0]  sel_s;
    logic [15:0] w [4];
    rst_s  = Reset;
    hold_s = bus.hold;
    mode_s = bus.mode;
    sel_s  = bus.sel;
    w[0]   = bus.in_sign1;
    w[1]   = bus.in_sign2;
    w[2]   = bus.in_sign3;
    w[3]   = bus.in_sign4;
    @(posedge CLK);
    #1;
    if (rst_s) begin
      m_cyc    = 0;
      m_idx    = 2'd0;
      m_frames = 0;
      m_snap   = 16'h0000;
    end else begin
      m_cyc++;
      if ((m_cyc % (4 * SD)) == 0 && !hold_s) begin
        if (!mode_s) begin
          m_idx = sel_s;
        end else begin
          m_frames++;
          if (m_frames >= RF) begin
            m_frames = 0;
            m_idx    = m_idx + 2'd1;
          end
        end
        m_snap = w[m_idx];
      end
    end
    model_compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    steps(2);
    Reset = 1'b0;
  endtask

  task automatic set_words(input logic [15:0] a, b, c, d);
    bus.in_sign1 = a;
    bus.in_sign2 = b;
    bus.in_sign3 = c;
    bus.in_sign4 = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset    = 1'b1;
    bus.mode = 1'b0;
    bus.sel  = 2'd0;
    bus.hold = 1'b0;
    set_words(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    m_cyc = 0; m_idx = 2'd0; m_frames = 0; m_snap = 16'h0000;

    vecs[0] = '{16'h1234, 2'd0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{16'h5678, 2'd1, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    vecs[2] = '{16'h9ABC, 2'd2, {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110}};
    vecs[3] = '{16'hDEF0, 2'd3, {7'b0100001, 7'b0000110, 7'b0001110, 7'b1000000}};

    // Reset state
    do_reset();
    check("rst_an",      32'(bus.an),      32'(4'b1110));
    check("rst_seg",     32'(bus.seg),     32'(7'b1000000));
    check("rst_dp",      32'(bus.dp),      32'(1'b0));
    check("rst_cur_sel", 32'(bus.cur_sel), 32'(2'd0));

    // Table vectors: manual select, full hex decode, digit order
    for (int v = 0; v < 4; v++) begin
      logic [3:0] e_an;
      do_reset();
      set_words(~vecs[v].word, ~vecs[v].word, ~vecs[v].word, ~vecs[v].word);
      case (vecs[v].sel)
        2'd0: bus.in_sign1 = vecs[v].word;
        2'd1: bus.in_sign2 = vecs[v].word;
        2'd2: bus.in_sign3 = vecs[v].word;
        default: bus.in_sign4 = vecs[v].word;
      endcase
      bus.mode = 1'b0;
      bus.sel  = vecs[v].sel;
      steps(16);
      check("vec_cur_sel", 32'(bus.cur_sel), 32'(vecs[v].sel));
      for (int d = 0; d < 4; d++) begin
        e_an = 4'b1111;
        e_an[d] = 1'b0;
        check("vec_an",  32'(bus.an),  32'(e_an));
        check("vec_seg", 32'(bus.seg), 32'(vecs[v].seg_exp[d]));
        check("vec_dp",  32'(bus.dp),  32'((d == int'(vecs[v].sel)) ? 1'b0 : 1'b1));
        steps(4);
      end
    end

    // Auto rotate: one word step every 2 frames = 32 cycles
    do_reset();
    set_words(16'hAAA1, 16'hBBB2, 16'hCCC3, 16'hDDD4);
    bus.mode = 1'b1;
    steps(16);
    check("auto_first_frame_sel", 32'(bus.cur_sel), 32'(2'd0));
    check("auto_first_frame_seg", 32'(bus.seg),     32'(7'b1111001));
    steps(15);
    for (int k = 1; k <= 5; k++) begin
      logic [6:0] e_seg;
      check("auto_before_step", 32'(bus.cur_sel), 32'((k - 1) % 4));
      step();
      check("auto_after_step", 32'(bus.cur_sel), 32'(k % 4));
      case (k % 4)
        0: e_seg = 7'b1111001;
        1: e_seg = 7'b0100100;
        2: e_seg = 7'b0110000;
        default: e_seg = 7'b0011001;
      endcase
      check("auto_snapshot_seg", 32'(bus.seg), 32'(e_seg));
      if (k < 5) steps(31);
    end

    // Hold freezes word and snapshot for 3 frames, scan keeps going
    bus.mode = 1'b0;
    do_reset();
    set_words(16'h1234, 16'h5678, 16'h9ABC, 16'h4321);
    bus.sel = 2'd0;
    steps(16);
    bus.hold = 1'b1;
    bus.in_sign1 = 16'hFFFF;
    bus.sel = 2'd3;
    steps(6);
    check("hold_an_scanning", 32'(bus.an), 32'(4'b1101));
    steps(42);
    check("hold_cur_sel", 32'(bus.cur_sel), 32'(2'd0));
    check("hold_seg",     32'(bus.seg),     32'(7'b0011001));
    bus.hold = 1'b0;
    steps(15);
    check("release_before_boundary", 32'(bus.cur_sel), 32'(2'd0));
    step();
    check("release_cur_sel", 32'(bus.cur_sel), 32'(2'd3));
    check("release_seg",     32'(bus.seg),     32'(7'b1111001));
    check("release_dp",      32'(bus.dp),      32'(1'b1));

    // sel change mid-frame only takes effect at the boundary
    do_reset();
    set_words(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    bus.sel = 2'd0;
    steps(21);
    bus.sel = 2'd2;
    steps(10);
    check("midframe_sel_ignored", 32'(bus.cur_sel), 32'(2'd0));
    step();
    check("midframe_sel_applied", 32'(bus.cur_sel), 32'(2'd2));
    check("midframe_snapshot",    32'(bus.seg),     32'(7'b1000110));

    // Reset at digit 2, prescaler 3: no tick, no load, scan restarts
    do_reset();
    bus.sel = 2'd1;
    steps(27);
    check("pre_reset_an", 32'(bus.an), 32'(4'b1011));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midreset_an",      32'(bus.an),      32'(4'b1110));
    check("midreset_seg",     32'(bus.seg),     32'(7'b1000000));
    check("midreset_cur_sel", 32'(bus.cur_sel), 32'(2'd0));
    check("midreset_dp",      32'(bus.dp),      32'(1'b0));
    steps(3);
    check("restart_still_d0", 32'(bus.an), 32'(4'b1110));
    step();
    check("restart_d1",       32'(bus.an), 32'(4'b1101));

    // Randomized stimulus against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)   bus.in_sign1 = 16'($urandom);
      if ($urandom_range(0, 7) == 0)   bus.in_sign2 = 16'($urandom);
      if ($urandom_range(0, 7) == 0)   bus.in_sign3 = 16'($urandom);
      if ($urandom_range(0, 7) == 0)   bus.in_sign4 = 16'($urandom);
      if ($urandom_range(0, 99) == 0)  bus.mode     = ~bus.mode;
      if ($urandom_range(0, 9) == 0)   bus.sel      = 2'($urandom);
      if ($urandom_range(0, 59) == 0)  bus.hold     = ~bus.hold;
      Reset = ($urandom_range(0, 499) == 0);
      step();
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debug_display_scheduler.md
DEBUG_DISPLAY_SCHEDULER -- requirements
Module: debug_display_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000: clocks per digit slot; legal values are 2 or more.
REQ-002 The block SHALL have parameter ROTATE_FRAMES, default 256: scan frames per word in auto mode; legal values are 1 or more.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports in_sign1..in_sign4, input, 16 bits each: debug words 0..3 to be displayed.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto rotate.
REQ-007 The block SHALL have port sel, input, 2 bits: manual word index.
REQ-008 The block SHALL have port hold, input, 1 bit: freezes the displayed word and the word index.
REQ-009 The block SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is the rightmost digit.
REQ-010 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-012 The block SHALL have port cur_sel, output, 2 bits: index of the word currently displayed.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = (prescaler == SCAN_DIV-1).
REQ-014 On tick, the digit counter SHALL advance mod 4 (0,1,2,3,0).
REQ-015 A frame boundary SHALL be the cycle where tick=1 and digit=3.
REQ-016 At a frame boundary with hold=0 and mode=0, the word index SHALL load sel.
REQ-017 At a frame boundary with hold=0 and mode=1, the frame counter SHALL increment; when it equals ROTATE_FRAMES-1 it SHALL wrap to 0 and the word index SHALL advance mod 4.
REQ-018 At a frame boundary with hold=0, the snapshot SHALL capture the in_sign word selected by the new word index on the same edge; in_sign1 corresponds to index 0.
REQ-019 With hold=1, the snapshot, word index and frame counter SHALL hold their values, while the prescaler and digit counter keep running.
REQ-020 Changes to mode or sel between frame boundaries SHALL have no effect until the next boundary.
REQ-021 an SHALL be ~(4'b0001 << digit).
REQ-022 seg SHALL show the hex decode of snapshot[4*digit+3 : 4*digit] using these active-low codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 dp SHALL be 0 when digit == word index and 1 otherwise.
REQ-024 cur_sel SHALL equal the word index.
REQ-025 an, seg, dp and cur_sel SHALL be combinational decodes of registered state only, with no combinational path from the inputs.
REQ-026 There SHALL be zero-cycle latency from a digit change to an/seg; snapshot data SHALL be visible starting the cycle after the boundary edge.

Reset
REQ-027 While Reset=1 at a rising CLK edge, the prescaler, digit, frame counter, word index and snapshot SHALL all clear to 0.
REQ-028 After reset the outputs SHALL be an=1110, seg=1000000, dp=0 and cur_sel=00.
REQ-029 Reset SHALL take priority over hold, mode and tick, and a mid-frame reset SHALL restart the scan at digit 0.

Verification (SCAN_DIV=4, ROTATE_FRAMES=2)
REQ-030 Reset for 2 cycles -> an=1110, seg=1000000, dp=0, cur_sel=0.
REQ-031 mode=0, sel=0, in_sign1=16'h1234 -> after the first boundary (edge 16) the snapshot is 1234; an steps 1110,1101,1011,0111 every 4 cycles while seg shows 0011001, 0110000, 0100100, 1111001.
REQ-032 mode=1 with distinct words -> cur_sel steps 0,1,2,3,0 once every 32 cycles, and each step coincides with a snapshot reload of the matching word.
REQ-033 hold=1, then in_sign1 changed to 16'hFFFF and sel=3 -> the snapshot and cur_sel are unchanged for 3 frames while an keeps scanning; releasing hold loads in_sign4 at the next boundary.
REQ-034 sel changed from 0 to 2 at cycle 5 of a frame -> cur_sel stays 0 until the boundary, then becomes 2 and the snapshot equals in_sign3.
REQ-035 Reset asserted at digit 2 with the prescaler at 3 -> on the next cycle all state is 0 and an=1110, with no tick and no snapshot load on that edge.
